menu_image_loader: RTL



---
 rtl/menu_image_loader_if.sv | 26 ++
 rtl/menu_image_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/menu_image_loader_if.sv
// Bundle between the menu image loader and its neighbours: UART byte stream
// in, draw-stage read port, and the load status flags.
interface menu_image_loader_if #(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 6
);
  logic                     start_i;
  logic [7:0]               rx_data_i;
  logic                     rx_valid_i;
  logic [X_BITS+Y_BITS-1:0] pixel_addr_i;
  logic [11:0]              rgb_pixel_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
  logic                     loaded_o;

  modport slave (
    input  start_i, rx_data_i, rx_valid_i, pixel_addr_i,
    output rgb_pixel_o, busy_o, done_o, err_o, loaded_o
  );

  modport master (
    output start_i, rx_data_i, rx_valid_i, pixel_addr_i,
    input  rgb_pixel_o, busy_o, done_o, err_o, loaded_o
  );
endinterface

// File: rtl/menu_image_loader.sv
// Menu image RAM: filled from a UART byte stream (sync byte, then hi/lo byte
// per pixel), read by the draw stage; reads are transparent until a full image is held.
//
// state | meaning
// IDLE  | no load in progress; waits for start
// SYNC  | armed; discarding bytes until SYNC_BYTE
// HI    | waiting for pixel high byte (red nibble)
// LO    | waiting for pixel low byte (green, blue); writes the pixel
module menu_image_loader #(
  parameter int          X_BITS      = 9,
  parameter int          Y_BITS      = 6,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT     = 1000000,
  parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
  input logic                 clk,
  input logic                 rst,
  menu_image_loader_if.slave  bus
);

  localparam int AW = X_BITS + Y_BITS;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SYNC, HI, LO} state_t;

  state_t            state_q;
  logic [X_BITS-1:0] col_q;
  logic [Y_BITS-1:0] row_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        red_q;
  logic              busy_q, done_q, err_q, loaded_q, rd_ok_q;
  logic [11:0]       rd_data_q;
  logic [11:0]       mem [0:(1<<AW)-1];

  logic          in_pixel, timed_out, last_px, wr_en;
  logic [AW-1:0] wr_addr, pix_d;

  always_comb begin
    in_pixel  = (state_q == HI) || (state_q == LO);
    wr_addr   = {row_q, col_q};
    pix_d     = wr_addr + AW'(1);
    last_px   = &wr_addr;
    wr_en     = (state_q == LO) && bus.rx_valid_i && !rst;
    // A byte arriving on the terminal count still wins over the abort.
    timed_out = in_pixel && !bus.rx_valid_i && (timer_q == TW'(TIMEOUT));
    timer_d   = '0;
    if (in_pixel && !bus.rx_valid_i)
      timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      timer_q  <= '0;
      red_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= timer_d;
      rd_ok_q <= loaded_q;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q  <= SYNC;
            busy_q   <= 1'b1;
            loaded_q <= 1'b0;
          end
        end
        SYNC: begin
          if (bus.rx_valid_i && bus.rx_data_i == SYNC_BYTE)
            state_q <= HI;
        end
        HI: begin
          if (bus.rx_valid_i) begin
            red_q   <= bus.rx_data_i[3:0];
            state_q <= LO;
          end else if (timed_out) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        LO: begin
          if (bus.rx_valid_i) begin
            {row_q, col_q} <= pix_d;
            if (last_px) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              loaded_q <= 1'b1;
            end else begin
              state_q <= HI;
            end
          end else if (timed_out) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM kept free of reset so it maps onto a simple dual-port block.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= {red_q, bus.rx_data_i};
    rd_data_q <= mem[bus.pixel_addr_i];
  end

  assign bus.rgb_pixel_o = rd_ok_q ? rd_data_q : TRANSPARENT;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.loaded_o    = loaded_q;

endmodule
